regfile_multiport: RTL and testbench
====================================

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, register select width; legal range 2..8.
REQ-003 SHALL have parameter NUM_RW, default 4, number of writable registers at addresses 0..NUM_RW-1; legal range 1..2^(ADDR_W-1).
REQ-004 SHALL have parameter CONST_BASE, default 2^(ADDR_W-1), base address of constant registers: CONST_BASE+0 = all-zeros, +1 = 1, +2 = all-ones.
REQ-005 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-006 i_rst_n  input  1  reset, synchronous, active-low.
REQ-007 i_clr  input  1  start sequential clear of all writable registers.
REQ-008 i_wrEn  input  1  write request.
REQ-009 i_wrSel  input  ADDR_W  write address.
REQ-010 i_wrData  input  DATA_W  write data.
REQ-011 i_rdEnA / i_rdEnB  input  1  read request, port A / B.
REQ-012 i_rdSelA / i_rdSelB  input  ADDR_W  read address, port A / B.
REQ-013 o_rdDataA / o_rdDataB  output  DATA_W  registered read data, port A / B.
REQ-014 o_rdValidA / o_rdValidB  output  1  read data valid, port A / B.
REQ-015 o_busy  output  1  clear sequence in progress.
REQ-016 o_wrErr  output  1  one-cycle pulse: previous write request was rejected.

Function
REQ-017 Read latency SHALL be exactly 1 cycle: rdEn sampled high at edge N -> rdData/rdValid updated at edge N, visible cycle N+1.
REQ-018 Ports A and B SHALL operate independently; both may read the same or different addresses in the same cycle.
REQ-019 Read of writable address SHALL return stored value; constant addresses per REQ-004; any other address SHALL return 0 with rdValid=1.
REQ-020 rdEn low SHALL clear rdValid next cycle and hold rdData at its last value.
REQ-021 Write with i_wrEn=1, o_busy=0, i_wrSel<NUM_RW SHALL update the register at that edge.
REQ-022 Write-to-read bypass: same-cycle write and read of the same writable address SHALL return i_wrData, not the old value; applies per port.
REQ-023 Write to i_wrSel>=NUM_RW SHALL leave storage unchanged and assert o_wrErr for exactly the following cycle.
REQ-024 Clear FSM states: IDLE, CLEAR. IDLE->CLEAR when i_clr=1 in IDLE; o_busy=1 from next cycle.
REQ-025 In CLEAR, an ADDR_W-bit index from 0 SHALL zero one register per cycle; after index NUM_RW-1 -> IDLE; o_busy high exactly NUM_RW cycles.
REQ-026 i_clr while in CLEAR SHALL be ignored (no restart, no extension).
REQ-027 Write request while o_busy=1 SHALL be dropped and SHALL pulse o_wrErr next cycle.
REQ-028 Read request while o_busy=1 SHALL be ignored: rdValid=0 next cycle, rdData held.
REQ-029 i_clr and i_wrEn in the same IDLE cycle: write SHALL commit, then clear SHALL overwrite it.
REQ-030 Back-to-back writes every cycle SHALL be accepted with no stall.

Reset
REQ-031 i_rst_n low at an edge SHALL set all writable registers to 0, o_rdDataA/B=0, o_rdValidA/B=0, o_busy=0, o_wrErr=0, FSM=IDLE, clear index=0.
REQ-032 Reset SHALL take priority over i_clr, writes and reads in the same cycle.
REQ-033 Reset during CLEAR SHALL abort to IDLE; o_busy=0 from the next cycle.

Verification
REQ-034 Default params: write 0x5A to reg 2, next cycle read A=2 -> o_rdDataA=0x5A, o_rdValidA=1 one cycle later.
REQ-035 Same cycle write 0x3C to reg 1 and read A=1, B=1 -> both ports return 0x3C next cycle (bypass).
REQ-036 Read A=8, B=10; then A=9, B=5 -> 0x00/0xFF, then 0x01/0x00, all valid.
REQ-037 Write 0x77 to reg 9 -> o_wrErr=1 for one cycle; read reg 9 still 0x01.
REQ-038 Fill regs 0-3 with 0x11..0x44, pulse i_clr -> o_busy high 4 cycles; write during busy pulses o_wrErr; after, all regs read 0x00.
REQ-039 Assert i_rst_n=0 mid-clear, DATA_W=16 NUM_RW=6 -> o_busy=0 next cycle, all outputs 0, all regs read 0x0000.

Source files
------------

// File: rtl/regfile_multiport.sv
// Multi-port register file: NUM_RW writable registers, three constant registers, two registered
// read ports with write bypass, and a sequential clear engine that blocks access while busy.
module regfile_multiport #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned NUM_RW     = 4,
    parameter int unsigned CONST_BASE = 2 ** (ADDR_W - 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrSel,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic              i_rdEnA,
    input  logic [ADDR_W-1:0] i_rdSelA,
    input  logic              i_rdEnB,
    input  logic [ADDR_W-1:0] i_rdSelB,
    output logic [DATA_W-1:0] o_rdDataA,
    output logic              o_rdValidA,
    output logic [DATA_W-1:0] o_rdDataB,
    output logic              o_rdValidB,
    output logic              o_busy,
    output logic              o_wrErr
);

    localparam int unsigned     SelW     = ADDR_W + 1;
    localparam logic [ADDR_W:0] NumRw    = SelW'(NUM_RW);
    localparam logic [ADDR_W-1:0] SelOne  = ADDR_W'(CONST_BASE + 1);
    localparam logic [ADDR_W-1:0] SelOnes = ADDR_W'(CONST_BASE + 2);
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_RW - 1);

    typedef enum logic {StIdle, StClear} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   clr_idx_q;
    logic [DATA_W-1:0]   regs_q [NUM_RW];
    logic [DATA_W-1:0]   rd_a_d, rd_b_d;
    logic [DATA_W-1:0]   rd_a_q, rd_b_q;
    logic                valid_a_q, valid_b_q, wr_err_q;
    logic                busy, wr_ok, wr_bad;

    assign busy   = (state_q == StClear);
    assign wr_ok  = i_wrEn && !busy && ({1'b0, i_wrSel} < NumRw);
    assign wr_bad = i_wrEn && !wr_ok;

    // A same-cycle accepted write to the selected register wins over the stored value.
    function automatic logic [DATA_W-1:0] read_mux(input logic [ADDR_W-1:0] sel);
        logic [DATA_W-1:0] val;
        val = '0;
        if (wr_ok && (sel == i_wrSel)) begin
            val = i_wrData;
        end else if ({1'b0, sel} < NumRw) begin
            for (int unsigned i = 0; i < NUM_RW; i++) begin
                if (sel == ADDR_W'(i)) val = regs_q[i];
            end
        end else if (sel == SelOne) begin
            val = DATA_W'(1);
        end else if (sel == SelOnes) begin
            val = '1;
        end
        return val;
    endfunction

    always_comb begin
        rd_a_d = read_mux(i_rdSelA);
        rd_b_d = read_mux(i_rdSelB);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            clr_idx_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    clr_idx_q <= '0;
                    if (i_clr) state_q <= StClear;
                end
                StClear: begin
                    if (clr_idx_q == LastIdx) begin
                        state_q   <= StIdle;
                        clr_idx_q <= '0;
                    end else begin
                        clr_idx_q <= clr_idx_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NUM_RW; i++) regs_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_RW; i++) begin
                if (busy && (clr_idx_q == ADDR_W'(i))) begin
                    regs_q[i] <= '0;
                end else if (wr_ok && (i_wrSel == ADDR_W'(i))) begin
                    regs_q[i] <= i_wrData;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_a_q    <= '0;
            rd_b_q    <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            wr_err_q  <= wr_bad;
            valid_a_q <= i_rdEnA && !busy;
            valid_b_q <= i_rdEnB && !busy;
            if (i_rdEnA && !busy) rd_a_q <= rd_a_d;
            if (i_rdEnB && !busy) rd_b_q <= rd_b_d;
        end
    end

    assign o_rdDataA  = rd_a_q;
    assign o_rdDataB  = rd_b_q;
    assign o_rdValidA = valid_a_q;
    assign o_rdValidB = valid_b_q;
    assign o_busy     = busy;
    assign o_wrErr    = wr_err_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Randomized and directed bench for regfile_multiport (DATA_W=16, NUM_RW=6) against an
// array-based reference model.
module tb_regfile_multiport;

    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int NRW = 6;

    logic          clk = 1'b0;
    logic          rst_n, clr, wr_en, rd_en_a, rd_en_b;
    logic [AW-1:0] wr_sel, rd_sel_a, rd_sel_b;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data_a, rd_data_b;
    logic          rd_valid_a, rd_valid_b, busy, wr_err;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model state
    logic [DW-1:0] m_mem [NRW];
    int            m_busy_left;
    logic [DW-1:0] e_rda, e_rdb;
    logic          e_va, e_vb, e_err;

    regfile_multiport #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .NUM_RW(NRW)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_clr     (clr),
        .i_wrEn    (wr_en),
        .i_wrSel   (wr_sel),
        .i_wrData  (wr_data),
        .i_rdEnA   (rd_en_a),
        .i_rdSelA  (rd_sel_a),
        .i_rdEnB   (rd_en_b),
        .i_rdSelB  (rd_sel_b),
        .o_rdDataA (rd_data_a),
        .o_rdValidA(rd_valid_a),
        .o_rdDataB (rd_data_b),
        .o_rdValidB(rd_valid_b),
        .o_busy    (busy),
        .o_wrErr   (wr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] const_val(input int sel);
        if (sel == 9)  return 16'h0001;
        if (sel == 10) return 16'hFFFF;
        return 16'h0000;
    endfunction

    function automatic logic [DW-1:0] view(input logic [DW-1:0] mem [NRW], input int sel);
        if (sel < NRW) return mem[sel];
        return const_val(sel);
    endfunction

    // Architectural effect of one clock edge with the current inputs.
    task automatic model_step();
        logic [DW-1:0] nxt [NRW];
        logic          bsy, wok;
        int            ws;
        if (!rst_n) begin
            for (int i = 0; i < NRW; i++) m_mem[i] = '0;
            m_busy_left = 0;
            e_rda = '0; e_rdb = '0; e_va = 1'b0; e_vb = 1'b0; e_err = 1'b0;
        end else begin
            ws  = int'(wr_sel);
            bsy = (m_busy_left > 0);
            wok = wr_en && !bsy && (ws < NRW);
            nxt = m_mem;
            if (wok) nxt[ws] = wr_data;
            e_err = wr_en && !wok;
            e_va  = rd_en_a && !bsy;
            e_vb  = rd_en_b && !bsy;
            if (e_va) e_rda = view(nxt, int'(rd_sel_a));
            if (e_vb) e_rdb = view(nxt, int'(rd_sel_b));
            if (bsy) begin
                nxt[NRW - m_busy_left] = '0;
                m_busy_left--;
            end else if (clr) begin
                m_busy_left = NRW;
            end
            m_mem = nxt;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("rdDataA", 32'(rd_data_a), 32'(e_rda));
        check("rdValidA", 32'(rd_valid_a), 32'(e_va));
        check("rdDataB", 32'(rd_data_b), 32'(e_rdb));
        check("rdValidB", 32'(rd_valid_b), 32'(e_vb));
        check("busy", 32'(busy), 32'(m_busy_left > 0));
        check("wrErr", 32'(wr_err), 32'(e_err));
    endtask

    task automatic idle();
        rst_n = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
    endtask

    task automatic wr(input int sel, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_sel = AW'(sel); wr_data = d;
    endtask

    task automatic rd(input int sa, input int sb);
        rd_en_a = 1'b1; rd_sel_a = AW'(sa); rd_en_b = 1'b1; rd_sel_b = AW'(sb);
    endtask

    task automatic fill();
        for (int i = 0; i < NRW; i++) begin
            idle(); wr(i, DW'(16'h11 * (i + 1))); cycle();
        end
    endtask

    initial begin
        int cnt;
        wr_sel = '0; rd_sel_a = '0; rd_sel_b = '0; wr_data = '0;
        idle(); rst_n = 1'b0;
        repeat (2) cycle();
        check("reset_busy", 32'(busy), 32'd0);

        // Write then read one cycle later
        idle(); wr(2, 16'h005A); cycle();
        idle(); rd_en_a = 1'b1; rd_sel_a = 4'd2; cycle();
        check("wr_then_rd", 32'(rd_data_a), 32'h5A);
        check("wr_then_rd_v", 32'(rd_valid_a), 32'd1);

        // Same-cycle bypass on both ports
        idle(); wr(1, 16'h003C); rd(1, 1); cycle();
        check("bypass_a", 32'(rd_data_a), 32'h3C);
        check("bypass_b", 32'(rd_data_b), 32'h3C);

        // Constant and unmapped addresses
        idle(); rd(8, 10); cycle();
        check("const_zero", 32'(rd_data_a), 32'h0);
        check("const_ones", 32'(rd_data_b), 32'hFFFF);
        idle(); rd(9, 11); cycle();
        check("const_one", 32'(rd_data_a), 32'h1);
        check("unmapped", 32'(rd_data_b), 32'h0);
        check("unmapped_v", 32'(rd_valid_b), 32'd1);

        // rdEn low holds data, drops valid
        idle(); cycle();
        check("hold_data", 32'(rd_data_a), 32'h1);
        check("hold_valid", 32'(rd_valid_a), 32'd0);

        // Illegal write address
        idle(); wr(9, 16'h0077); cycle();
        check("wrerr_pulse", 32'(wr_err), 32'd1);
        idle(); rd_en_a = 1'b1; rd_sel_a = 4'd9; cycle();
        check("wrerr_one_cycle", 32'(wr_err), 32'd0);
        check("const_kept", 32'(rd_data_a), 32'h1);

        // Back-to-back fill, then clear with a write, a re-clear and a read while busy
        fill();
        idle(); clr = 1'b1; cycle();
        cnt = busy ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy) break;
            idle();
            clr = (k == 2);
            if (k == 1) wr(0, 16'hBEEF);
            if (k == 3) rd(0, 1);
            cycle();
            if (busy) cnt++;
        end
        check("busy_cycles", 32'(cnt), 32'(NRW));
        for (int i = 0; i < NRW; i++) begin
            idle(); rd(i, NRW - 1 - i); cycle();
            check("cleared", 32'(rd_data_a), 32'h0);
        end

        // Write and clear in the same idle cycle: clear wins in the end
        idle(); wr(3, 16'hABCD); clr = 1'b1; cycle();
        for (int k = 0; k < 20 && busy; k++) begin
            idle(); cycle();
        end
        idle(); rd(3, 3); cycle();
        check("wr_clr_same", 32'(rd_data_a), 32'h0);

        // Reset mid-clear
        fill();
        idle(); rd(4, 5); cycle();
        idle(); clr = 1'b1; cycle();
        idle(); cycle();
        idle(); rst_n = 1'b0; wr(5, 16'h1234); rd(4, 5); clr = 1'b1; cycle();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rda", 32'(rd_data_a), 32'h0);
        check("rst_rdb", 32'(rd_data_b), 32'h0);
        check("rst_va", 32'(rd_valid_a), 32'd0);
        for (int i = 0; i < NRW; i++) begin
            idle(); rd(i, i); cycle();
            check("rst_regs", 32'(rd_data_b), 32'h0);
        end

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst_n    = ($urandom_range(0, 63) != 0);
            clr      = ($urandom_range(0, 15) == 0);
            wr_en    = $urandom_range(0, 1) == 1;
            wr_sel   = AW'($urandom_range(0, 15));
            wr_data  = DW'($urandom);
            rd_en_a  = $urandom_range(0, 3) != 0;
            rd_en_b  = $urandom_range(0, 3) != 0;
            rd_sel_a = ($urandom_range(0, 1) == 1) ? wr_sel : AW'($urandom_range(0, 15));
            rd_sel_b = AW'($urandom_range(0, 15));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
